// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and state encoding for the memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int WORD_SIZE_DEF    = 16;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    I_RD = 3'd1,
    D_RD = 3'd2,
    D_WR = 3'd3,
    RESP = 3'd4
  } arb_state_t;

  function automatic logic is_access(input arb_state_t s);
    return (s == I_RD) || (s == D_RD) || (s == D_WR);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating count of D grants made while the I-port waits; flags when I must win.
module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_limit
);

  localparam int              CW  = $clog2(LIMIT + 1);
  localparam logic [CW-1:0]   LIM = CW'(LIMIT);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIM)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_at_limit = (r_count == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch (I) and data (D) requesters.
// D has fixed priority; a starvation guard forces an I grant after STARVE_LIMIT D wins.
//   state | meaning
//   IDLE  | arbitrate, latch address/wdata of the winner
//   I_RD  | fetch read, readM held until inputReady
//   D_RD  | data read, readM held until inputReady
//   D_WR  | data write, writeM and data bus driven until inputReady
//   RESP  | ack pulse visible, requests ignored
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = WORD_SIZE_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_req,
  input  logic [WORD_SIZE-1:0] i_addr,
  output logic                 i_ack,
  output logic [WORD_SIZE-1:0] i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_ack,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  output logic [WORD_SIZE-1:0] num_i_grants,
  output logic [WORD_SIZE-1:0] num_d_grants
);

  arb_state_t r_state, w_next_state;
  logic w_grant_d, w_grant_i, w_starved, w_done;

  logic [WORD_SIZE-1:0] r_addr, r_wdata;
  logic [WORD_SIZE-1:0] r_i_rdata, r_d_rdata;
  logic [WORD_SIZE-1:0] r_num_i, r_num_d;
  logic                 r_i_ack, r_d_ack;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    readM        = 1'b0;
    writeM       = 1'b0;
    case (r_state)
      IDLE: begin
        if (d_req && (!i_req || !w_starved)) begin
          w_grant_d    = 1'b1;
          w_next_state = d_we ? D_WR : D_RD;
        end else if (i_req) begin
          w_grant_i    = 1'b1;
          w_next_state = I_RD;
        end
      end
      I_RD, D_RD: begin
        readM = 1'b1;
        if (inputReady) w_next_state = RESP;
      end
      D_WR: begin
        writeM = 1'b1;
        if (inputReady) w_next_state = RESP;
      end
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign w_done = inputReady && is_access(r_state);

  // Requester inputs are only looked at on the grant edge; the bus runs from latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_num_i   <= '0;
      r_num_d   <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_d_ack <= 1'b0;
      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
      end else if (w_grant_i) begin
        r_addr <= i_addr;
      end
      if (w_done) begin
        case (r_state)
          I_RD: begin
            r_i_ack   <= 1'b1;
            r_i_rdata <= data;
            r_num_i   <= r_num_i + 1'b1;
          end
          D_RD: begin
            r_d_ack   <= 1'b1;
            r_d_rdata <= data;
            r_num_d   <= r_num_d + 1'b1;
          end
          default: begin
            r_d_ack <= 1'b1;
            r_num_d <= r_num_d + 1'b1;
          end
        endcase
      end
    end
  end

  arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (w_grant_d && i_req),
    .i_clr      (w_grant_i || ((r_state == IDLE) && !i_req)),
    .o_at_limit (w_starved)
  );

  assign data         = (r_state == D_WR) ? r_wdata : 'z;
  assign address      = r_addr;
  assign i_ack        = r_i_ack;
  assign d_ack        = r_d_ack;
  assign i_rdata      = r_i_rdata;
  assign d_rdata      = r_d_rdata;
  assign num_i_grants = r_num_i;
  assign num_d_grants = r_num_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a memory responder and an ack scoreboard.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int W = 16;
  localparam logic [W-1:0] IDLE_PAT = 16'hA5C3;
  localparam logic [W-1:0] RD_KEY   = 16'h6A11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         i_req, i_ack, d_req, d_we, d_ack;
  logic [W-1:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic         readM, writeM, inputReady;
  logic [W-1:0] address, num_i_grants, num_d_grants;
  wire  [W-1:0] data;

  // Memory returns address ^ RD_KEY on reads and parks a known pattern when no strobe is up.
  assign data = readM ? (address ^ RD_KEY) : (!writeM ? IDLE_PAT : 'z);

  mem_port_arbiter #(.WORD_SIZE(W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .readM(readM), .writeM(writeM), .address(address), .data(data),
    .inputReady(inputReady),
    .num_i_grants(num_i_grants), .num_d_grants(num_d_grants)
  );

  // Narrow instance so the grant-counter wrap is reachable in a few dozen cycles.
  logic       s_i_req, s_i_ack, s_d_req, s_d_we, s_d_ack, s_readM, s_writeM;
  logic [3:0] s_i_addr, s_i_rdata, s_d_addr, s_d_wdata, s_d_rdata, s_address;
  logic [3:0] s_num_i, s_num_d;
  wire  [3:0] s_data;

  mem_port_arbiter #(.WORD_SIZE(4), .STARVE_LIMIT(4)) dut_s (
    .clk(clk), .reset(reset),
    .i_req(s_i_req), .i_addr(s_i_addr), .i_ack(s_i_ack), .i_rdata(s_i_rdata),
    .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata),
    .d_ack(s_d_ack), .d_rdata(s_d_rdata),
    .readM(s_readM), .writeM(s_writeM), .address(s_address), .data(s_data),
    .inputReady(s_writeM),
    .num_i_grants(s_num_i), .num_d_grants(s_num_d)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic         is_d;
    logic [W-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t popped;
  logic [W-1:0] exp_i_rdata, exp_d_rdata;

  // Memory responder: inputReady after mem_wait extra access cycles.
  int mem_wait = 0;
  int mem_cnt  = 0;
  initial inputReady = 1'b0;
  always @(negedge clk) begin
    if (readM || writeM) begin
      inputReady = (mem_cnt >= mem_wait);
      mem_cnt++;
    end else begin
      inputReady = 1'b0;
      mem_cnt    = 0;
    end
  end

  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    if (!reset && (i_ack || d_ack)) begin
      check("ack_single_pulse", prev_ack, 1'b0);
      check("ack_exclusive", i_ack & d_ack, 1'b0);
      check("ack_expected", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        popped = sb.pop_front();
        check("ack_owner", d_ack, popped.is_d);
        if (popped.is_d) check("d_rdata", d_rdata, popped.rdata);
        else             check("i_rdata", i_rdata, popped.rdata);
      end
    end
    prev_ack = i_ack | d_ack;
  end

  task automatic wait_ack(input int budget);
    logic got;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      @(negedge clk);
      if (i_ack || d_ack) got = 1'b1;
    end
    check("ack_timeout", got, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int edges, wcycles, s_acks;
    logic got;

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    s_i_req = 1'b0; s_i_addr = '0; s_d_req = 1'b0; s_d_we = 1'b0;
    s_d_addr = '0; s_d_wdata = '0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    repeat (2) @(negedge clk);

    check("rst_readM", readM, 1'b0);
    check("rst_writeM", writeM, 1'b0);
    check("rst_address", address, 16'h0000);
    check("rst_i_ack", i_ack, 1'b0);
    check("rst_d_ack", d_ack, 1'b0);
    check("rst_i_rdata", i_rdata, 16'h0000);
    check("rst_d_rdata", d_rdata, 16'h0000);
    check("rst_num_i", num_i_grants, 16'h0000);
    check("rst_num_d", num_d_grants, 16'h0000);
    check("rst_bus_released", data, IDLE_PAT);
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, no wait states.
    i_req = 1'b1; i_addr = 16'h0010;
    exp_i_rdata = 16'h0010 ^ RD_KEY;
    sb.push_back('{is_d: 1'b0, rdata: exp_i_rdata});
    edges = 0;
    do begin
      @(negedge clk);
      edges++;
    end while (!i_ack && edges < 10);
    check("fetch_latency", edges, 2);
    check("fetch_rdata_value", i_rdata, 16'h6A01);
    i_req = 1'b0;
    @(negedge clk);
    check("fetch_ack_drop", i_ack, 1'b0);
    check("fetch_num_i", num_i_grants, 16'd1);
    check("fetch_i_rdata_held", i_rdata, 16'h6A01);

    // Data read establishes a known d_rdata.
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
    exp_d_rdata = 16'h0030 ^ RD_KEY;
    sb.push_back('{is_d: 1'b1, rdata: exp_d_rdata});
    wait_ack(20);
    d_req = 1'b0;
    @(negedge clk);
    check("dread_num_d", num_d_grants, 16'd1);

    // Write with three wait states.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
    mem_wait = 3;
    sb.push_back('{is_d: 1'b1, rdata: exp_d_rdata});
    wcycles = 0;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (writeM) begin
        wcycles++;
        check("wr_addr_held", address, 16'h0040);
        check("wr_data_driven", data, 16'hBEEF);
      end else begin
        check("wr_bus_released", data, IDLE_PAT);
      end
      if (d_ack) got = 1'b1;
    end
    check("wr_ack_seen", got, 1'b1);
    check("wr_strobe_cycles", wcycles, 4);
    check("wr_keeps_d_rdata", d_rdata, 16'h0030 ^ RD_KEY);
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    check("wr_num_d", num_d_grants, 16'd2);

    // Requester changes its address after the grant.
    d_req = 1'b1; d_addr = 16'h0050; mem_wait = 2;
    exp_d_rdata = 16'h0050 ^ RD_KEY;
    sb.push_back('{is_d: 1'b1, rdata: exp_d_rdata});
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (readM) begin
        check("latched_addr", address, 16'h0050);
        d_addr = 16'hFFFF;
      end
      if (d_ack) got = 1'b1;
    end
    check("chg_ack_seen", got, 1'b1);
    d_req = 1'b0; d_addr = '0; mem_wait = 0;
    @(negedge clk);

    // Contention: both held; expected order D,D,D,D,I,D,D,D,D,I.
    i_addr = 16'h0100; d_addr = 16'h0200; d_we = 1'b0;
    for (int n = 0; n < 10; n++) begin
      if (n == 4 || n == 9) sb.push_back('{is_d: 1'b0, rdata: 16'h0100 ^ RD_KEY});
      else                  sb.push_back('{is_d: 1'b1, rdata: 16'h0200 ^ RD_KEY});
    end
    exp_i_rdata = 16'h0100 ^ RD_KEY;
    exp_d_rdata = 16'h0200 ^ RD_KEY;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 10; n++) wait_ack(10);
    i_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    check("cont_num_i", num_i_grants, 16'd3);
    check("cont_num_d", num_d_grants, 16'd11);
    check("scoreboard_drained", sb.size(), 0);
    check("cont_i_rdata_held", i_rdata, exp_i_rdata);

    // Reset in the middle of a slow data read.
    d_req = 1'b1; d_addr = 16'h0060; mem_wait = 20;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (readM) got = 1'b1;
    end
    check("mid_rd_started", got, 1'b1);
    reset = 1'b1; d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_readM", readM, 1'b0);
    check("mid_rst_bus", data, IDLE_PAT);
    check("mid_rst_num_d", num_d_grants, 16'd0);
    check("mid_rst_num_i", num_i_grants, 16'd0);
    check("mid_rst_d_ack", d_ack, 1'b0);
    check("mid_rst_d_rdata", d_rdata, 16'h0000);
    repeat (5) @(negedge clk);
    mem_wait = 0;

    // Grant counter wrap on the 4-bit instance: 15 writes then one more.
    s_d_req = 1'b1; s_d_we = 1'b1; s_d_addr = 4'h9; s_d_wdata = 4'h6;
    s_acks = 0;
    for (int k = 0; k < 100 && s_acks < 16; k++) begin
      @(negedge clk);
      if (s_writeM && k < 4) begin
        check("s_wr_data", s_data, 4'h6);
        check("s_wr_addr", s_address, 4'h9);
      end
      if (s_d_ack) begin
        s_acks++;
        if (s_acks == 15) check("wrap_pre", s_num_d, 4'hF);
        if (s_acks == 16) check("wrap_zero", s_num_d, 4'h0);
      end
    end
    check("wrap_ack_count", s_acks, 16);
    s_d_req = 1'b0;
    @(negedge clk);
    check("s_num_i", s_num_i, 4'h0);
    check("s_i_ack", s_i_ack, 1'b0);
    check("s_i_rdata", s_i_rdata, 4'h0);
    check("s_d_rdata", s_d_rdata, 4'h0);
    check("s_readM", s_readM, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
